btn_in_rep: RTL and testbench
=============================

# btn_in_rep

Parametrised push-button front end for the clock-setting panel. It takes N active-low, asynchronous button inputs and resynchronises each one. Each input is debounced by sampling on a divided-down tick. Per channel it produces a debounced level, a one-cycle press pulse with optional hold-to-auto-repeat, and a one-cycle release pulse. It sits between the board pins and the time-setting/mode logic, and is the successor to the fixed 3-button, press-only input block.

## Interface
- N, 3: number of button channels (≥1).
- DIV, 1200000: sample-tick period in CLK cycles (≥1); 1200000 gives 40 Hz at 48 MHz.
- HOLD, 20: ticks from press edge to first auto-repeat pulse (≥1).
- RATE, 4: ticks between subsequent auto-repeat pulses (1 ≤ RATE ≤ HOLD).
- REP_MASK, {N{1'b1}}: per-channel auto-repeat enable; bit=0 means press pulse only.

- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- nBIN  in  N  raw buttons, active-low, asynchronous to CLK.
- BOUT  out  N  press/repeat pulse, one CLK wide per event.
- BREL  out  N  release pulse, one CLK wide.
- BLVL  out  N  debounced level, 1 = pressed.

## Operation
- Synchroniser: two CLK flops per channel, s1→s2, reset to all-ones (released). All later logic uses s2 only.
- Prescaler: counter of width clog2(DIV) (min 1), 0..DIV-1, wraps to 0.
  - tick = (cnt == DIV-1).
  - DIV=1 gives tick every cycle.
- Sample register smp[N-1:0], reset all-ones, loads s2 on tick.
- Debounce rule, per channel, evaluated on tick:
  - Let cur = ~s2 and prev = ~smp.
  - If cur == prev and cur != BLVL, then BLVL ← cur.
  - A 0→1 change is a press edge; a 1→0 change is a release edge.
  - A change must therefore be seen on two consecutive ticks. A one-tick glitch is ignored.
- Repeat counter hc per channel, width clog2(HOLD+1). Evaluated on tick:
  - Press edge: hc ← 0.
  - BLVL=1 with no edge and REP_MASK bit set:
    - If hc == HOLD-1: repeat event, hc ← HOLD-RATE.
    - Else: hc ← hc+1.
  - BLVL=0 or release edge: hc ← 0.
  - REP_MASK bit=0: hc held at 0, never repeats.
- Repeat events fall at HOLD, HOLD+RATE, HOLD+2·RATE, … ticks after the press-edge tick.
- Outputs are registered:
  - BOUT ← {press edge | repeat event} & {N{tick}}.
  - BREL ← {release edge} & {N{tick}}.
  - Both are 0 in every non-tick cycle.
- Channels are fully independent. Simultaneous events on different channels pulse in the same cycle.
- A press edge and a repeat event cannot coincide on one channel.
- Reset: cnt=0, s1/s2/smp all-ones, BLVL=0, BOUT=0, BREL=0, hc=0.
  - Reset overrides tick in the same cycle.
  - A button held through reset re-qualifies as a fresh press after reset releases.

## Timing
- BOUT/BREL are high for exactly the one CLK cycle following the tick that detects the event.
- BLVL changes in the same cycle as the BOUT/BREL pulse.
- Input-change-to-pulse latency: 2 CLK synchroniser, plus 1–2 ticks of qualification, plus 1 CLK register. Worst case is 2·DIV+3 CLK.
- Repeat pulses are spaced exactly RATE·DIV CLK cycles apart. The first repeat comes HOLD·DIV CLK after the press pulse.
- Release always produces BREL, even mid-repeat. No BOUT follows a release edge.
- First tick after reset occurs at CLK cycle DIV after RST deasserts.

## Test plan
Bench parameters: N=3, DIV=4, HOLD=5, RATE=2, REP_MASK=3'b011.

1. Assert RST for 3 cycles with nBIN=3'b000 (all pressed), then release.
   - During reset: BLVL=0, BOUT=0, BREL=0.
   - After release: BOUT=3'b001 | 3'b010 | 3'b100 in one cycle at the second post-reset tick, and BLVL=3'b111.
2. Drive nBIN[0] low for exactly 1 tick period (4 CLK) aligned between ticks.
   - No BOUT, no BREL, BLVL[0] stays 0.
3. Drive nBIN[0] low for 3 ticks, then high.
   - One BOUT[0] pulse, one CLK wide.
   - BLVL[0]=1 until the release-edge tick, then one BREL[0] pulse.
   - No repeat.
4. Hold nBIN[1] low for 14 ticks.
   - BOUT[1] at the press tick (T).
   - BOUT[1] again at T+5, T+7, T+9, T+11, T+13 (20, 28, … CLK apart after the first).
   - Release gives BREL[1] and no further BOUT[1].
5. Hold nBIN[2] low for 14 ticks (masked channel).
   - Exactly one BOUT[2] pulse.
   - BREL[2] on release.
6. Hold nBIN[1] low; assert RST at press tick T+6, mid-repeat.
   - Outputs are 0 next cycle.
   - After RST drops: fresh BOUT[1] at the second tick, then repeats at +5 and +7 ticks from that press.

Source files
------------

// File: rtl/btn_in_rep.sv
// btn_in_rep: push-button front end for the clock-setting panel.
// Each active-low asynchronous button is resynchronised, debounced on a
// divided-down sample tick and turned into a debounced level, a press pulse
// with optional hold-to-auto-repeat, and a release pulse.
module btn_in_rep #(
    parameter int            N        = 3,
    parameter int            DIV      = 1200000,
    parameter int            HOLD     = 20,
    parameter int            RATE     = 4,
    parameter logic [N-1:0]  REP_MASK = {N{1'b1}}
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] nBIN,
    output logic [N-1:0] BOUT,
    output logic [N-1:0] BREL,
    output logic [N-1:0] BLVL
);

    // Counter widths; a one-cycle prescaler still needs a one-bit register.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW = $clog2(HOLD + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [HW-1:0] HC_LAST   = HW'(HOLD - 1);
    localparam logic [HW-1:0] HC_RELOAD = HW'(HOLD - RATE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HC_ONE    = HW'(1);

    logic [N-1:0]  r_s1;
    logic [N-1:0]  r_s2;
    logic [N-1:0]  r_smp;
    logic [N-1:0]  r_lvl;
    logic [N-1:0]  r_bout;
    logic [N-1:0]  r_brel;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hc     [N];

    logic          w_tick;
    logic [N-1:0]  w_cur;
    logic [N-1:0]  w_prev;
    logic [N-1:0]  w_qual;
    logic [N-1:0]  w_press;
    logic [N-1:0]  w_release;
    logic [N-1:0]  w_rep;
    logic [HW-1:0] w_hcNext [N];

    // A change qualifies only when the current and previous tick samples agree
    // and differ from the debounced level; its direction picks press or release.
    assign w_tick    = (r_cnt == CNT_LAST);
    assign w_cur     = ~r_s2;
    assign w_prev    = ~r_smp;
    assign w_qual    = ~(w_cur ^ w_prev) & (w_cur ^ r_lvl);
    assign w_press   = w_qual & w_cur;
    assign w_release = w_qual & ~w_cur;

    assign BOUT = r_bout;
    assign BREL = r_brel;
    assign BLVL = r_lvl;

    // Two-flop synchroniser per channel; idles at released (all ones).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= nBIN;
            r_s2 <= r_s1;
        end
    end

    // Prescaler producing one sample tick every DIV cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Sample register and debounced level, both advanced only on a tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_smp <= '1;
            r_lvl <= '0;
        end else if (w_tick) begin
            r_smp <= r_s2;
            r_lvl <= (r_lvl & ~w_qual) | (w_cur & w_qual);
        end
    end

    // Hold/repeat counter next state: restart on press, count while held on
    // repeat-enabled channels, reload after each repeat to space them by RATE.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_hcNext[i] = '0;
            w_rep[i]    = 1'b0;
            if (w_press[i]) begin
                w_hcNext[i] = '0;
            end else if (r_lvl[i] && !w_release[i] && REP_MASK[i]) begin
                if (r_hc[i] == HC_LAST) begin
                    w_rep[i]    = 1'b1;
                    w_hcNext[i] = HC_RELOAD;
                end else begin
                    w_hcNext[i] = r_hc[i] + HC_ONE;
                end
            end
        end
    end

    // Repeat counters update on ticks only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                r_hc[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < N; i++) begin
                r_hc[i] <= w_hcNext[i];
            end
        end
    end

    // Registered one-cycle event pulses; zero in every non-tick cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bout <= '0;
            r_brel <= '0;
        end else begin
            r_bout <= (w_press | w_rep) & {N{w_tick}};
            r_brel <= w_release & {N{w_tick}};
        end
    end

endmodule

// File: tb/tb_btn_in_rep.sv
// Testbench for btn_in_rep: directed scenarios plus random button activity,
// all checked against a tick-level behavioural model of the button rules.
module tb_btn_in_rep;

    localparam int         N        = 3;
    localparam int         DIV      = 4;
    localparam int         HOLD     = 5;
    localparam int         RATE     = 2;
    localparam logic [2:0] REP_MASK = 3'b011;

    logic       CLK  = 1'b0;
    logic       RST  = 1'b1;
    logic [2:0] nBIN = 3'b111;
    logic [2:0] BOUT;
    logic [2:0] BREL;
    logic [2:0] BLVL;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycNum      = 0;

    // Reference model state
    logic [2:0] mPipe0 = 3'b111;
    logic [2:0] mPipe1 = 3'b111;
    logic [2:0] mLast  = 3'b111;
    logic [2:0] mLvl   = 3'b000;
    logic [2:0] expOut = 3'b000;
    logic [2:0] expRel = 3'b000;
    int         mCyc   = 0;
    int         mAge [N];

    btn_in_rep #(
        .N(N), .DIV(DIV), .HOLD(HOLD), .RATE(RATE), .REP_MASK(REP_MASK)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .nBIN(nBIN),
        .BOUT(BOUT),
        .BREL(BREL),
        .BLVL(BLVL)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Drive one clock cycle, then advance the model by that same edge.
    // Repeats are derived from tick age since the press edge.
    task automatic runCycle(input logic [2:0] nb, input logic rs);
        logic [2:0] s2;
        bit         tick;
        bit         cur;
        bit         prev;
        nBIN = nb;
        RST  = rs;
        @(posedge CLK);
        cycNum++;
        if (rs) begin
            mCyc   = 0;
            mPipe0 = 3'b111;
            mPipe1 = 3'b111;
            mLast  = 3'b111;
            mLvl   = 3'b000;
            expOut = 3'b000;
            expRel = 3'b000;
            for (int i = 0; i < N; i++) mAge[i] = 0;
        end else begin
            tick   = ((mCyc % DIV) == DIV - 1);
            s2     = mPipe1;
            expOut = 3'b000;
            expRel = 3'b000;
            if (tick) begin
                for (int ch = 0; ch < N; ch++) begin
                    cur  = !s2[ch];
                    prev = !mLast[ch];
                    if (cur == prev && cur != mLvl[ch]) begin
                        if (cur) begin
                            expOut[ch] = 1'b1;
                            mAge[ch]   = 0;
                        end else begin
                            expRel[ch] = 1'b1;
                        end
                        mLvl[ch] = cur;
                    end else if (mLvl[ch] && REP_MASK[ch]) begin
                        mAge[ch]++;
                        if (mAge[ch] >= HOLD && ((mAge[ch] - HOLD) % RATE) == 0)
                            expOut[ch] = 1'b1;
                    end
                end
                mLast = s2;
            end
            mCyc++;
            mPipe1 = mPipe0;
            mPipe0 = nb;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            runCycle(3'b000, 1'b1);
            nCompared++;
            if ({BOUT, BREL, BLVL} !== 9'b0) begin
                nMismatched++;
                $display("FAIL reset_hold: got out=%b rel=%b lvl=%b want all 0", BOUT, BREL, BLVL);
            end
        end
        for (int k = 1; k <= 2 * DIV; k++) begin
            runCycle(3'b000, 1'b0);
            nCompared++;
            if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                nMismatched++;
                $display("FAIL reset_model: got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                         BOUT, BREL, BLVL, expOut, expRel, mLvl);
            end
            nCompared++;
            if (k < 2 * DIV && BOUT !== 3'b000) begin
                nMismatched++;
                $display("FAIL reset_early_press: cycle %0d got out=%b want 000", k, BOUT);
            end else if (k == 2 * DIV && (BOUT !== 3'b111 || BLVL !== 3'b111)) begin
                nMismatched++;
                $display("FAIL reset_requalify: got out=%b lvl=%b want out=111 lvl=111", BOUT, BLVL);
            end
        end
        for (int k = 0; k < 3 * DIV + 4; k++) begin
            runCycle(3'b111, 1'b0);
            nCompared++;
            if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                nMismatched++;
                $display("FAIL reset_release: got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                         BOUT, BREL, BLVL, expOut, expRel, mLvl);
            end
        end
    endtask

    task automatic test_glitch();
        int events = 0;
        for (int k = 0; k < 4 * DIV + 3 * DIV; k++) begin
            runCycle((k >= 2 && k < 2 + DIV) ? 3'b110 : 3'b111, 1'b0);
            if (BOUT[0] || BREL[0]) events++;
            nCompared++;
            if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                nMismatched++;
                $display("FAIL glitch_model: got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                         BOUT, BREL, BLVL, expOut, expRel, mLvl);
            end
            nCompared++;
            if (BLVL[0] !== 1'b0) begin
                nMismatched++;
                $display("FAIL glitch_level: got lvl0=%b want 0", BLVL[0]);
            end
        end
        nCompared++;
        if (events != 0) begin
            nMismatched++;
            $display("FAIL glitch_events: got %0d pulses want 0", events);
        end
    endtask

    task automatic test_press_release();
        int presses  = 0;
        int releases = 0;
        for (int k = 0; k < 3 * DIV + 5 * DIV; k++) begin
            runCycle((k < 3 * DIV) ? 3'b110 : 3'b111, 1'b0);
            if (BOUT[0]) presses++;
            if (BREL[0]) releases++;
            nCompared++;
            if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                nMismatched++;
                $display("FAIL press_model: got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                         BOUT, BREL, BLVL, expOut, expRel, mLvl);
            end
        end
        nCompared++;
        if (presses != 1 || releases != 1) begin
            nMismatched++;
            $display("FAIL press_counts: got press=%0d rel=%0d want 1 and 1", presses, releases);
        end
    endtask

    task automatic test_repeat();
        int pulseCyc[$];
        int relCyc   = -1;
        int lateOut  = 0;
        int releases = 0;
        int gaps [5] = '{20, 8, 8, 8, 8};
        for (int k = 0; k < 14 * DIV + 5 * DIV; k++) begin
            runCycle((k < 14 * DIV) ? 3'b101 : 3'b111, 1'b0);
            if (BOUT[1]) begin
                pulseCyc.push_back(cycNum);
                if (relCyc >= 0) lateOut++;
            end
            if (BREL[1]) begin
                releases++;
                relCyc = cycNum;
            end
            nCompared++;
            if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                nMismatched++;
                $display("FAIL repeat_model: got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                         BOUT, BREL, BLVL, expOut, expRel, mLvl);
            end
        end
        nCompared++;
        if (pulseCyc.size() != 6) begin
            nMismatched++;
            $display("FAIL repeat_count: got %0d pulses want 6", pulseCyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nCompared++;
                if (pulseCyc[i + 1] - pulseCyc[i] != gaps[i]) begin
                    nMismatched++;
                    $display("FAIL repeat_gap%0d: got %0d cycles want %0d", i,
                             pulseCyc[i + 1] - pulseCyc[i], gaps[i]);
                end
            end
        end
        nCompared++;
        if (releases != 1 || lateOut != 0) begin
            nMismatched++;
            $display("FAIL repeat_release: got rel=%0d late_out=%0d want 1 and 0", releases, lateOut);
        end
    endtask

    task automatic test_masked();
        int presses  = 0;
        int releases = 0;
        for (int k = 0; k < 14 * DIV + 5 * DIV; k++) begin
            runCycle((k < 14 * DIV) ? 3'b011 : 3'b111, 1'b0);
            if (BOUT[2]) presses++;
            if (BREL[2]) releases++;
            nCompared++;
            if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                nMismatched++;
                $display("FAIL masked_model: got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                         BOUT, BREL, BLVL, expOut, expRel, mLvl);
            end
        end
        nCompared++;
        if (presses != 1 || releases != 1) begin
            nMismatched++;
            $display("FAIL masked_counts: got press=%0d rel=%0d want 1 and 1", presses, releases);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int  budget = 0;
        int  offs[$];
        int  want [3] = '{2 * DIV, 2 * DIV + HOLD * DIV, 2 * DIV + (HOLD + RATE) * DIV};
        bit  seen = 0;
        while (!seen && budget < 10 * DIV) begin
            runCycle(3'b101, 1'b0);
            budget++;
            if (BOUT[1]) seen = 1;
        end
        nCompared++;
        if (!seen) begin
            nMismatched++;
            $display("FAIL midrst_press_timeout: got no BOUT[1] within %0d cycles want a press", budget);
        end
        for (int k = 0; k < 6 * DIV - 1; k++) runCycle(3'b101, 1'b0);
        runCycle(3'b101, 1'b1);
        nCompared++;
        if ({BOUT, BREL, BLVL} !== 9'b0) begin
            nMismatched++;
            $display("FAIL midrst_clear: got out=%b rel=%b lvl=%b want all 0", BOUT, BREL, BLVL);
        end
        runCycle(3'b101, 1'b1);
        for (int k = 1; k <= 10 * DIV; k++) begin
            runCycle(3'b101, 1'b0);
            if (BOUT[1]) offs.push_back(k);
            nCompared++;
            if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                nMismatched++;
                $display("FAIL midrst_model: got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                         BOUT, BREL, BLVL, expOut, expRel, mLvl);
            end
        end
        nCompared++;
        if (offs.size() != 3 || offs[0] != want[0] || offs[1] != want[1] || offs[2] != want[2]) begin
            nMismatched++;
            $display("FAIL midrst_pulses: got %0d pulses first=%0d want offsets %0d %0d %0d",
                     offs.size(), (offs.size() > 0) ? offs[0] : -1, want[0], want[1], want[2]);
        end
        for (int k = 0; k < 4 * DIV; k++) runCycle(3'b111, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] nb;
        int         len;
        logic       rs;
        for (int seg = 0; seg < 150; seg++) begin
            nb  = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 14);
            rs  = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < len; k++) begin
                runCycle(nb, (k == 0) ? rs : 1'b0);
                nCompared++;
                if ({BOUT, BREL, BLVL} !== {expOut, expRel, mLvl}) begin
                    nMismatched++;
                    $display("FAIL random_model: cyc %0d got out=%b rel=%b lvl=%b want out=%b rel=%b lvl=%b",
                             cycNum, BOUT, BREL, BLVL, expOut, expRel, mLvl);
                end
            end
        end
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        for (int i = 0; i < N; i++) mAge[i] = 0;
        test_reset();
        test_glitch();
        test_press_release();
        test_repeat();
        test_masked();
        test_reset_mid_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
